pe_array_ctrl: RTL and testbench
================================

// Module: pe_array_ctrl
// PURPOSE
//  Sequencer for a ROWS x COLS weight-stationary PE array. Each PE holds an 8-bit weight, multiplies it by ifmap and forwards ifmap one row down per cycle.
//  Per job: loads every PE weight from a weight-buffer stream, then streams cfg_len ifmap beats into row 0.
//  Generates per-row PE enables skewed to match the ifmap pipeline, then drains the array.
//  Sits between the layer scheduler (start/done) and the PE array plus its weight/ifmap buffers.
// PARAMETERS
//  ROWS   4   PE rows; ifmap pipeline depth
//  COLS   4   PE columns
//  LEN_W  10  width of cfg_len (max beats per job = 2**LEN_W-1)
// PORTS
//  clk         in   1          clock
//  rst_n       in   1          reset, asynchronous, active-low
//  start       in   1          job request; sampled only in IDLE
//  cfg_len     in   LEN_W      ifmap beats for this job; latched on accepted start
//  keep_w      in   1          reuse loaded weights (only with PE_CTRL_WEIGHT_REUSE_EN)
//  w_valid     in   1          weight buffer has a beat on the shared w_in bus
//  w_ready     out  1          weight beat accepted this cycle
//  w_load_en   out  ROWS*COLS  one-hot; PE index = row*COLS+col
//  if_valid    in   1          ifmap buffer has a beat for row 0
//  if_ready    out  1          ifmap beat accepted this cycle
//  pe_en       out  ROWS       PE_en per row; bit r drives every PE in row r
//  out_valid   out  1          last-row products are valid this cycle
//  busy        out  1          job in progress (state != IDLE)
//  done        out  1          one-cycle pulse when the job completes
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0. Counters and skew register cleared.
//  FSM: IDLE -> WLOAD -> COMPUTE -> DRAIN -> FIN -> IDLE.
//   IDLE: start=1 latches cfg_len, clears counters, goes to WLOAD.
//   WLOAD: w_ready=1. When w_valid&&w_ready, w_load_en bit widx is 1 in that same cycle and widx increments.
//     After beat ROWS*COLS-1 is accepted: go to COMPUTE, or to DRAIN if latched len==0.
//   COMPUTE: if_ready=1. A beat is accepted when if_valid&&if_ready; then pe_en[0]=1 that same cycle, else pe_en[0]=0.
//     Bubbles are allowed. After beat len-1 is accepted, go to DRAIN.
//   DRAIN: pe_en[0]=0. Stay exactly ROWS-1 cycles so the skew empties, then go to FIN.
//   FIN: done=1 for one cycle; next state IDLE. busy drops in the cycle after done.
//  Skew: pe_en[r] = pe_en[0] delayed r cycles (registered shift), r=1..ROWS-1.
//  out_valid = pe_en[ROWS-1].
//  Latency: start accepted -> WLOAD on the next cycle. Best case start->done = 1 + ROWS*COLS + len + ROWS-1 cycles.
//  start while busy: ignored and not queued. w_valid/if_valid outside their phase: ignored, ready stays 0.
//  Counters: widx is clog2(ROWS*COLS) bits; icnt is LEN_W bits. Neither wraps within a job; both clear on leaving IDLE.
//  Async reset mid-job: immediate IDLE, all enables 0. The PE array is reset by the same rst_n.
// CONFIGURATION
//  PE_CTRL_WEIGHT_REUSE_EN defined:
//   start with keep_w=1 goes IDLE -> COMPUTE (or DRAIN if len==0) and skips WLOAD.
//   Valid only after at least one full weight load since reset. A flag w_loaded is set on WLOAD exit and cleared by reset.
//   If w_loaded=0, keep_w is treated as 0.
//  Not defined: keep_w port is present but ignored; every job runs WLOAD.
// STRUCTURE
//  Package pe_ctrl_pkg:
//   - typedef enum logic [2:0] {IDLE,WLOAD,COMPUTE,DRAIN,FIN} pe_ctrl_state_e
//   - localparam PE_DATA_W=8, PE_PROD_W=16
//  Sub-module pe_en_skew: ROWS-deep enable shift register (in: en0; out: en[ROWS-1:0]; async clear).
//  FSM, widx/icnt/drain counters and one-hot decode live in the top module.
// TESTING
//  1 Reset mid-WLOAD (widx=5) -> next cycle: state IDLE, w_load_en=0, pe_en=0, busy=0.
//  2 ROWS=COLS=4, cfg_len=8, w_valid/if_valid tied 1 -> w_load_en walks bits 0..15 over 16 cycles;
//    pe_en[0] high 8 cycles; pe_en[3] high 8 cycles starting 3 cycles later;
//    done exactly 28 cycles after start accepted (1 + 16 + 8 + 3).
//  3 w_valid toggling 1,0,1,0 -> w_load_en only on valid cycles; exactly 16 distinct one-hot bits, none repeated.
//  4 cfg_len=0 -> WLOAD completes, if_ready never asserts, pe_en stays 0, done after 3 DRAIN cycles.
//  5 start pulsed during COMPUTE -> ignored; exactly one done per accepted start.
//  6 (macro on) second job with keep_w=1, len=4 -> no w_ready, pe_en[0] high on the first if_valid after start.
//    keep_w=1 right after reset -> full WLOAD runs.

Source files
------------

// File: rtl/pe_ctrl_pkg.sv
// Shared types and constants for the weight-stationary PE array sequencer.
// Imported by pe_en_skew and pe_array_ctrl.
package pe_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WLOAD,
    COMPUTE,
    DRAIN,
    FIN
  } pe_ctrl_state_e;

  localparam int PE_DATA_W = 8;
  localparam int PE_PROD_W = 16;

endpackage

// File: rtl/pe_en_skew.sv
// Row-enable skew: en[r] is en0 delayed r cycles to follow the ifmap
// as it ripples down the array. Cleared by the async reset.
module pe_en_skew #(
  parameter int ROWS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en0,
  output logic [ROWS-1:0] en
);

  if (ROWS > 1) begin : g_sr
    logic [ROWS-2:0] q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q <= '0;
      end else begin
        q[0] <= en0;
        for (int i = 1; i < ROWS-1; i++) begin
          q[i] <= q[i-1];
        end
      end
    end

    assign en = {q, en0};
  end else begin : g_pass
    assign en = en0;
  end

endmodule

// File: rtl/pe_array_ctrl.sv
// Job sequencer for a ROWS x COLS weight-stationary PE array.
// Optional macro PE_CTRL_WEIGHT_REUSE_EN lets keep_w skip the weight load.
module pe_array_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int LEN_W = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_W-1:0]     cfg_len,
  input  logic                 keep_w,
  input  logic                 w_valid,
  output logic                 w_ready,
  output logic [ROWS*COLS-1:0] w_load_en,
  input  logic                 if_valid,
  output logic                 if_ready,
  output logic [ROWS-1:0]      pe_en,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int NPE  = ROWS * COLS;
  localparam int WI_W = (NPE > 1) ? $clog2(NPE) : 1;
  localparam int DC_W = (ROWS > 2) ? $clog2(ROWS) : 1;

  localparam logic [WI_W-1:0] W_LAST = WI_W'(NPE - 1);
  localparam logic [DC_W-1:0] D_LAST = DC_W'(ROWS - 2);

  pe_ctrl_state_e state;
  pe_ctrl_state_e nxt;

  logic [LEN_W-1:0] len_q;
  logic [WI_W-1:0]  widx;
  logic [LEN_W-1:0] icnt;
  logic [DC_W-1:0]  dcnt;

  logic w_acc;
  logic i_acc;
  logic reuse;

  assign w_acc = w_ready && w_valid;
  assign i_acc = if_ready && if_valid;

`ifdef PE_CTRL_WEIGHT_REUSE_EN
  logic w_loaded;

  assign reuse = keep_w && w_loaded;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_loaded <= 1'b0;
    end else if (state == WLOAD && nxt != WLOAD) begin
      w_loaded <= 1'b1;
    end
  end
`else
  logic unused_keep;

  assign unused_keep = keep_w;
  assign reuse       = 1'b0;
`endif

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (!reuse) nxt = WLOAD;
          else if (cfg_len == '0) nxt = DRAIN;
          else nxt = COMPUTE;
        end
      end
      WLOAD: begin
        if (w_acc && widx == W_LAST) begin
          nxt = (len_q == '0) ? DRAIN : COMPUTE;
        end
      end
      COMPUTE: begin
        if (i_acc && icnt == len_q - LEN_W'(1)) begin
          nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (dcnt == D_LAST) nxt = FIN;
      end
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Handshake/status outputs are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      w_ready  <= 1'b0;
      if_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= nxt;
      w_ready  <= (nxt == WLOAD);
      if_ready <= (nxt == COMPUTE);
      busy     <= (nxt != IDLE);
      done     <= (nxt == FIN);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= '0;
      widx  <= '0;
      icnt  <= '0;
      dcnt  <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        len_q <= cfg_len;
        widx  <= '0;
        icnt  <= '0;
        dcnt  <= '0;
      end
    end else begin
      if (w_acc) widx <= widx + WI_W'(1);
      if (i_acc) icnt <= icnt + LEN_W'(1);
      if (state == DRAIN) dcnt <= dcnt + DC_W'(1);
    end
  end

  assign w_load_en = w_acc ? (NPE'(1) << widx) : '0;

  pe_en_skew #(
    .ROWS (ROWS)
  ) u_skew (
    .clk   (clk),
    .rst_n (rst_n),
    .en0   (i_acc),
    .en    (pe_en)
  );

  assign out_valid = pe_en[ROWS-1];

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Directed bench for pe_array_ctrl (ROWS=COLS=4, LEN_W=10).
// Reuse checks switch with PE_CTRL_WEIGHT_REUSE_EN.
module tb_pe_array_ctrl;
  import pe_ctrl_pkg::*;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int LEN_W = 10;
  localparam int NPE   = ROWS * COLS;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] cfg_len;
  logic             keep_w;
  logic             w_valid;
  logic             w_ready;
  logic [NPE-1:0]   w_load_en;
  logic             if_valid;
  logic             if_ready;
  logic [ROWS-1:0]  pe_en;
  logic             out_valid;
  logic             busy;
  logic             done;

  int tests;
  int fails;

  logic [NPE-1:0] mask;
  int wbeats, wrep, wbad, worder, wr_cyc, ifr_cyc;
  int pe0_n, pe0_first, pe3_n, pe3_first, ov_err;
  int done_n, done_cyc;
  logic busy_after;

  pe_array_ctrl #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .LEN_W (LEN_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cfg_len   (cfg_len),
    .keep_w    (keep_w),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_load_en (w_load_en),
    .if_valid  (if_valid),
    .if_ready  (if_ready),
    .pe_en     (pe_en),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle 0 is the start cycle; cycle k is the k-th cycle after it.
  task automatic run_job(input int len, input bit wtog, input bit keep,
                         input int spulse, input int ncyc);
    mask = '0;
    wbeats = 0; wrep = 0; wbad = 0; worder = 0;
    wr_cyc = 0; ifr_cyc = 0;
    pe0_n = 0; pe0_first = -1; pe3_n = 0; pe3_first = -1;
    ov_err = 0; done_n = 0; done_cyc = -1; busy_after = 1'b1;
    @(negedge clk);
    start = 1'b1;
    cfg_len = LEN_W'(len);
    keep_w = keep;
    w_valid = 1'b0;
    if_valid = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      start = (k == spulse);
      w_valid = wtog ? k[0] : 1'b1;
      if_valid = 1'b1;
      #1;
      if (w_load_en != '0) begin
        if (!w_valid) wbad++;
        if (w_load_en != (NPE'(1) << wbeats)) worder++;
        if ((mask & w_load_en) != '0) wrep++;
        mask = mask | w_load_en;
        wbeats++;
      end
      if (w_ready) wr_cyc++;
      if (if_ready) ifr_cyc++;
      if (pe_en[0]) begin
        if (pe0_first < 0) pe0_first = k;
        pe0_n++;
      end
      if (pe_en[ROWS-1]) begin
        if (pe3_first < 0) pe3_first = k;
        pe3_n++;
      end
      if (out_valid !== pe_en[ROWS-1]) ov_err++;
      if (done_n > 0 && done_cyc == k - 1) busy_after = busy;
      if (done) begin
        done_n++;
        if (done_n == 1) done_cyc = k;
      end
    end
    start = 1'b0;
    keep_w = 1'b0;
    w_valid = 1'b0;
    if_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0; cfg_len = '0; keep_w = 1'b0;
    w_valid = 1'b0; if_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL reset_status: busy=%b done=%b want 0 0", busy, done);
      fails++;
    end
    tests++;
    if (w_ready !== 1'b0 || if_ready !== 1'b0) begin
      $display("FAIL reset_ready: w=%b if=%b want 0 0", w_ready, if_ready);
      fails++;
    end
    tests++;
    if (w_load_en !== '0 || pe_en !== '0 || out_valid !== 1'b0) begin
      $display("FAIL reset_en: wl=%h pe=%b ov=%b want 0", w_load_en, pe_en, out_valid);
      fails++;
    end
  endtask

  task automatic test_keep_after_reset();
    run_job(2, 1'b0, 1'b1, 0, 40);
    tests++;
    if (wr_cyc != 16) begin
      $display("FAIL keep_reset_wload: w_ready cycles %0d want 16", wr_cyc);
      fails++;
    end
    tests++;
    if (done_cyc != 22) begin
      $display("FAIL keep_reset_done: cycle %0d want 22", done_cyc);
      fails++;
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    start = 1'b1;
    cfg_len = LEN_W'(8);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      start = 1'b0;
      w_valid = 1'b1;
    end
    #1;
    tests++;
    if (w_load_en !== NPE'(32) || busy !== 1'b1) begin
      $display("FAIL mid_widx5: wl=%h busy=%b want 0020 1", w_load_en, busy);
      fails++;
    end
    #1 rst_n = 1'b0;
    @(negedge clk);
    #1;
    tests++;
    if (dut.state !== IDLE || busy !== 1'b0) begin
      $display("FAIL mid_reset_state: state=%0d busy=%b want 0 0", dut.state, busy);
      fails++;
    end
    tests++;
    if (w_load_en !== '0 || pe_en !== '0 || w_ready !== 1'b0) begin
      $display("FAIL mid_reset_en: wl=%h pe=%b wr=%b want 0", w_load_en, pe_en, w_ready);
      fails++;
    end
    rst_n = 1'b1;
    w_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full_job();
    run_job(8, 1'b0, 1'b0, 0, 40);
    tests++;
    if (wbeats != 16 || mask != '1 || worder != 0) begin
      $display("FAIL full_wload: beats=%0d mask=%h order_err=%0d want 16 ffff 0",
               wbeats, mask, worder);
      fails++;
    end
    tests++;
    if (pe0_first != 17 || pe0_n != 8) begin
      $display("FAIL full_pe0: first=%0d n=%0d want 17 8", pe0_first, pe0_n);
      fails++;
    end
    tests++;
    if (pe3_first != 20 || pe3_n != 8 || ov_err != 0) begin
      $display("FAIL full_pe3: first=%0d n=%0d ov_err=%0d want 20 8 0",
               pe3_first, pe3_n, ov_err);
      fails++;
    end
    tests++;
    if (done_cyc != 28 || done_n != 1) begin
      $display("FAIL full_done: cycle=%0d n=%0d want 28 1", done_cyc, done_n);
      fails++;
    end
    tests++;
    if (busy_after !== 1'b0) begin
      $display("FAIL full_busy_drop: busy=%b want 0", busy_after);
      fails++;
    end
  endtask

  task automatic test_wvalid_toggle();
    run_job(4, 1'b1, 1'b0, 0, 60);
    tests++;
    if (wbad != 0 || wrep != 0) begin
      $display("FAIL tog_onehot: invalid=%0d repeat=%0d want 0 0", wbad, wrep);
      fails++;
    end
    tests++;
    if (wbeats != 16 || mask != '1 || worder != 0) begin
      $display("FAIL tog_beats: beats=%0d mask=%h order_err=%0d want 16 ffff 0",
               wbeats, mask, worder);
      fails++;
    end
    tests++;
    if (wr_cyc != 31 || done_cyc != 39) begin
      $display("FAIL tog_timing: wr_cyc=%0d done=%0d want 31 39", wr_cyc, done_cyc);
      fails++;
    end
  endtask

  task automatic test_len_zero();
    run_job(0, 1'b0, 1'b0, 0, 40);
    tests++;
    if (ifr_cyc != 0 || pe0_n != 0 || pe3_n != 0) begin
      $display("FAIL len0_idle: if_ready=%0d pe0=%0d pe3=%0d want 0 0 0",
               ifr_cyc, pe0_n, pe3_n);
      fails++;
    end
    tests++;
    if (done_cyc != 20 || done_n != 1 || wbeats != 16) begin
      $display("FAIL len0_done: cycle=%0d n=%0d beats=%0d want 20 1 16",
               done_cyc, done_n, wbeats);
      fails++;
    end
  endtask

  task automatic test_start_ignored();
    run_job(8, 1'b0, 1'b0, 20, 60);
    tests++;
    if (done_n != 1 || done_cyc != 28) begin
      $display("FAIL start_busy: dones=%0d cycle=%0d want 1 28", done_n, done_cyc);
      fails++;
    end
  endtask

  task automatic test_weight_reuse();
`ifdef PE_CTRL_WEIGHT_REUSE_EN
    run_job(4, 1'b0, 1'b1, 0, 30);
    tests++;
    if (wr_cyc != 0 || wbeats != 0) begin
      $display("FAIL reuse_skip: w_ready=%0d beats=%0d want 0 0", wr_cyc, wbeats);
      fails++;
    end
    tests++;
    if (pe0_first != 1 || pe0_n != 4 || done_cyc != 8) begin
      $display("FAIL reuse_run: first=%0d n=%0d done=%0d want 1 4 8",
               pe0_first, pe0_n, done_cyc);
      fails++;
    end
`else
    run_job(4, 1'b0, 1'b1, 0, 40);
    tests++;
    if (wr_cyc != 16 || wbeats != 16) begin
      $display("FAIL keep_ignored: w_ready=%0d beats=%0d want 16 16", wr_cyc, wbeats);
      fails++;
    end
    tests++;
    if (done_cyc != 24) begin
      $display("FAIL keep_ignored_done: cycle=%0d want 24", done_cyc);
      fails++;
    end
`endif
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_keep_after_reset();
    test_mid_reset();
    test_full_job();
    test_wvalid_toggle();
    test_len_zero();
    test_start_ignored();
    test_weight_reuse();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
